// File: rtl/sequencer_pkg.sv
// Shared opcodes, FSM state encoding and control-word bundle
// for the basic 8-bit processor sequencer.
package sequencer_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_BNE   = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_X0   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef struct packed {
    logic pc_bus;
    logic inc_pc;
    logic load_pc;
    logic addr_bus;
    logic load_ir;
    logic load_mar;
    logic mdr_bus;
    logic load_mdr;
    logic cs;
    logic r_nw;
    logic acc_bus;
    logic load_acc;
    logic alu_acc;
    logic alu_add;
    logic alu_sub;
    logic alu_xor;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational control decode: (state, op, z_flag) -> control word.
// Ports: i_state, i_op, i_z_flag in; o_ctrl out.
module seq_decode
  import sequencer_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_op,
  input  logic       i_z_flag,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_F0: begin
        o_ctrl.pc_bus   = 1'b1;
        o_ctrl.load_mar = 1'b1;
        o_ctrl.inc_pc   = 1'b1;
      end
      S_F1: begin
        o_ctrl.cs      = 1'b1;
        o_ctrl.r_nw    = 1'b1;
        o_ctrl.mdr_bus = 1'b1;
        o_ctrl.load_ir = 1'b1;
      end
      S_F2: begin
        o_ctrl.addr_bus = 1'b1;
        o_ctrl.load_mar = 1'b1;
      end
      S_X0: begin
        case (i_op)
          OP_LOAD, OP_ADD, OP_SUB, OP_XOR: begin
            o_ctrl.cs       = 1'b1;
            o_ctrl.r_nw     = 1'b1;
            o_ctrl.mdr_bus  = 1'b1;
            o_ctrl.load_acc = 1'b1;
            o_ctrl.alu_acc  = (i_op != OP_LOAD);
            o_ctrl.alu_add  = (i_op == OP_ADD);
            o_ctrl.alu_sub  = (i_op == OP_SUB);
            o_ctrl.alu_xor  = (i_op == OP_XOR);
          end
          OP_STORE: begin
            o_ctrl.acc_bus  = 1'b1;
            o_ctrl.load_mdr = 1'b1;
            o_ctrl.cs       = 1'b1;
          end
          OP_JMP: begin
            o_ctrl.addr_bus = 1'b1;
            o_ctrl.load_pc  = 1'b1;
          end
          OP_BNE: begin
            o_ctrl.addr_bus = ~i_z_flag;
            o_ctrl.load_pc  = ~i_z_flag;
          end
          default: ;
        endcase
      end
      S_HALT: o_ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/sequencer.sv
// Sequencer top: state register, retired-instruction counter, decode.
// Ports: clock, n_reset, op, z_flag in; bus/load/memory strobes, halted, instr_count out.
module sequencer
  import sequencer_pkg::*;
#(
  parameter int OP_W    = 3,
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               n_reset,
  input  logic [OP_W-1:0]    op,
  input  logic               z_flag,
  output logic               PC_bus,
  output logic               INC_PC,
  output logic               load_PC,
  output logic               Addr_bus,
  output logic               load_IR,
  output logic               load_MAR,
  output logic               MDR_bus,
  output logic               load_MDR,
  output logic               CS,
  output logic               R_NW,
  output logic               ACC_bus,
  output logic               load_ACC,
  output logic               ALU_ACC,
  output logic               ALU_add,
  output logic               ALU_sub,
  output logic               ALU_xor,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  state_t             r_state;
  logic [COUNT_W-1:0] r_count;
  logic [2:0]         w_op;
  ctrl_t              w_ctrl;

  // Opcode lives in the top bits of the op field.
  assign w_op = op[OP_W-1 -: 3];

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_RST;
      r_count <= '0;
    end else begin
      case (r_state)
        S_RST: r_state <= S_F0;
        S_F0:  r_state <= S_F1;
        S_F1:  r_state <= S_F2;
        S_F2:  r_state <= (w_op == OP_HALT) ? S_HALT : S_X0;
        S_X0: begin
          r_state <= S_F0;
          r_count <= r_count + 1'b1;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_RST;
      endcase
    end
  end

  seq_decode u_dec (
    .i_state  (r_state),
    .i_op     (w_op),
    .i_z_flag (z_flag),
    .o_ctrl   (w_ctrl)
  );

  assign PC_bus      = w_ctrl.pc_bus;
  assign INC_PC      = w_ctrl.inc_pc;
  assign load_PC     = w_ctrl.load_pc;
  assign Addr_bus    = w_ctrl.addr_bus;
  assign load_IR     = w_ctrl.load_ir;
  assign load_MAR    = w_ctrl.load_mar;
  assign MDR_bus     = w_ctrl.mdr_bus;
  assign load_MDR    = w_ctrl.load_mdr;
  assign CS          = w_ctrl.cs;
  assign R_NW        = w_ctrl.r_nw;
  assign ACC_bus     = w_ctrl.acc_bus;
  assign load_ACC    = w_ctrl.load_acc;
  assign ALU_ACC     = w_ctrl.alu_acc;
  assign ALU_add     = w_ctrl.alu_add;
  assign ALU_sub     = w_ctrl.alu_sub;
  assign ALU_xor     = w_ctrl.alu_xor;
  assign halted      = w_ctrl.halted;
  assign instr_count = r_count;

endmodule

// File: doc/sequencer.md
Name: sequencer

Overview:
- Control-unit state machine for the 8-bit basic processor.
- Sits upstream of the memory (ROM/RAM), PC, IR and ALU/ACC blocks on the shared tri-state sysbus.
- Drives every bus-enable, register-load, memory chip-select and read/write strobe that moves each fetch/execute step.
- Consumes only the IR opcode field and the ALU zero flag; also counts retired instructions and reports halt.

Parameters:
- OP_W, 3, opcode width (top bits of instruction word).
- COUNT_W, 8, width of retired-instruction counter.

Ports:
- clock  input  1  system clock, all state on rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- op  input  OP_W  opcode field from IR (registered upstream).
- z_flag  input  1  ALU accumulator-zero flag.
- PC_bus  output  1  PC drives sysbus.
- INC_PC  output  1  PC increments at next edge.
- load_PC  output  1  PC loads from sysbus.
- Addr_bus  output  1  IR address field drives sysbus.
- load_IR  output  1  IR loads from sysbus.
- load_MAR  output  1  memory MAR loads from sysbus.
- MDR_bus  output  1  memory data drives sysbus.
- load_MDR  output  1  memory MDR loads from sysbus.
- CS  output  1  memory chip select.
- R_NW  output  1  1 = read, 0 = write (meaningful only when CS=1).
- ACC_bus  output  1  ACC drives sysbus.
- load_ACC  output  1  ACC loads (from sysbus or ALU result).
- ALU_ACC  output  1  ACC takes ALU result instead of sysbus.
- ALU_add, ALU_sub, ALU_xor  output  1 each  ALU function select, one-hot, used only with ALU_ACC.
- halted  output  1  processor stopped.
- instr_count  output  COUNT_W  retired instructions, wraps.

Behaviour:
- Opcodes: LOAD 000, STORE 001, ADD 010, SUB 011, XOR 100, BNE 101, JMP 110, HALT 111.
- States: S_RST, S_F0, S_F1, S_F2, S_X0, S_HALT.
- Outputs are Moore decodes of the state register plus the op input (S_X0 only). All outputs not listed for a state are 0.
- At most one sysbus driver is asserted in any state.
- Reset (async): state = S_RST, instr_count = 0, all control outputs 0, halted = 0.
- S_RST: no outputs; unconditional -> S_F0. This gives one idle cycle after reset release.
- S_F0: PC_bus, load_MAR, INC_PC -> S_F1.
- S_F1: CS, R_NW, MDR_bus, load_IR -> S_F2.
- S_F2: Addr_bus, load_MAR. If op == HALT -> S_HALT, else -> S_X0.
- S_X0, per op:
  - LOAD: CS, R_NW, MDR_bus, load_ACC.
  - ADD / SUB / XOR: CS, R_NW, MDR_bus, load_ACC, ALU_ACC plus ALU_add / ALU_sub / ALU_xor respectively.
  - STORE: ACC_bus, load_MDR, CS, R_NW = 0.
  - JMP: Addr_bus, load_PC.
  - BNE: Addr_bus and load_PC only when z_flag = 0; otherwise no outputs.
  - Then -> S_F0, and instr_count increments by 1 modulo 2^COUNT_W.
- Latency: every non-HALT instruction takes exactly 4 cycles (F0, F1, F2, X0).
- S_HALT: halted = 1, all other controls 0. Stays in S_HALT until reset. HALT does not increment instr_count.
- z_flag is sampled combinationally in S_X0 only; changes in any other state are ignored.
- op is ignored outside S_F2 and S_X0.
- Reset asserted mid-instruction: immediate return to S_RST, with all strobes deasserted asynchronously.

Decomposition:
- Package sequencer_pkg holds:
  - opcode localparams (matching the shared opcode header encodings);
  - state enum typedef, state_t, logic [2:0];
  - control-word struct typedef bundling the 17 control outputs.
- One sub-module is natural: seq_decode, purely combinational (state, op, z_flag -> control struct).
- The top holds the state register and instr_count.

Test Plan:
- Reset release -> 1 cycle all-zero (S_RST), then F0 asserts PC_bus/load_MAR/INC_PC, F1 asserts CS/R_NW=1/MDR_bus/load_IR, F2 asserts Addr_bus/load_MAR.
- op = 000 (LOAD) at F2 -> X0 asserts CS, R_NW=1, MDR_bus, load_ACC only; next cycle is F0; instr_count 0 -> 1.
- op = 001 (STORE) -> X0 asserts ACC_bus, load_MDR, CS, R_NW=0; no MDR_bus.
- op = 011 (SUB) -> X0 asserts ALU_ACC, ALU_sub, load_ACC, MDR_bus; ALU_add = ALU_xor = 0.
- op = 101 (BNE) with z_flag = 0 -> load_PC = 1 and Addr_bus = 1; same with z_flag = 1 -> no strobes; both retire (count +1).
- op = 111 (HALT) -> after F2 halted = 1 permanently, instr_count frozen. 255 non-HALT instructions followed by one more -> instr_count wraps 255 -> 0. Reset pulse during F1 -> outputs 0 immediately, restart at S_RST.
